// File: rtl/dmem_arb_pkg.sv
// Shared types and funct3 encodings for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } req_t;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } size_t;

    // Encodings that are neither byte nor halfword are checked as words.
    function automatic size_t access_size(input logic [2:0] funct3);
        size_t sz;
        case (funct3)
            F3_B, F3_BU: sz = SzByte;
            F3_H, F3_HU: sz = SzHalf;
            default:     sz = SzWord;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_arb_align_chk.sv
// Combinational alignment and range check for one data-memory access.
module dmem_arb_align_chk
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    output logic        err
);

    // One extra bit so a memory filling the whole address space cannot overflow.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    logic misaligned;
    logic out_of_range;

    always_comb begin
        misaligned = 1'b0;
        unique case (access_size(funct3))
            SzByte:  misaligned = 1'b0;
            SzHalf:  misaligned = addr[0];
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    assign out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
    assign err          = misaligned | out_of_range;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ISSUE -> RESP per transaction.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed p0 priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req_valid,
    input  logic        p1_req_valid,
    output logic        p0_req_ready,
    output logic        p1_req_ready,
    input  logic        p0_req_write,
    input  logic        p1_req_write,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p0_req_wdata,
    input  logic [31:0] p1_req_wdata,
    input  logic [2:0]  p0_req_funct3,
    input  logic [2:0]  p1_req_funct3,
    output logic        p0_rsp_valid,
    output logic        p1_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic [31:0] p1_rsp_rdata,
    output logic        p0_rsp_err,
    output logic        p1_rsp_err,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    req_t        issue_q;
    logic        issue_port_q;
    logic [31:0] rsp_rdata0_q, rsp_rdata1_q;
    logic        rsp_err0_q, rsp_err1_q;

    req_t        req0, req1;
    logic        gnt0, gnt1;
    logic        handshake;
    logic        issue_err;
    logic        in_issue;
    logic        in_resp;
    logic [31:0] rsp_word;

`ifdef DMEM_ARB_RR_EN
    logic        rr_p1_q;
`endif

    assign req0 = '{write: p0_req_write, addr: p0_req_addr, wdata: p0_req_wdata,
                    funct3: p0_req_funct3};
    assign req1 = '{write: p1_req_write, addr: p1_req_addr, wdata: p1_req_wdata,
                    funct3: p1_req_funct3};

    dmem_arb_align_chk #(
        .MEM_WORDS(MEM_WORDS)
    ) u_align_chk (
        .addr  (issue_q.addr),
        .funct3(issue_q.funct3),
        .err   (issue_err)
    );

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && !rst) begin
`ifdef DMEM_ARB_RR_EN
            if (p0_req_valid && p1_req_valid) begin
                gnt0 = !rr_p1_q;
                gnt1 = rr_p1_q;
            end else begin
                gnt0 = p0_req_valid;
                gnt1 = p1_req_valid;
            end
`else
            gnt0 = p0_req_valid;
            gnt1 = p1_req_valid && !p0_req_valid;
`endif
        end
    end

    assign handshake = gnt0 | gnt1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (handshake) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rsp_word = (issue_q.write || issue_err) ? 32'h0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            issue_q      <= '0;
            issue_port_q <= 1'b0;
            rsp_rdata0_q <= 32'h0;
            rsp_rdata1_q <= 32'h0;
            rsp_err0_q   <= 1'b0;
            rsp_err1_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_p1_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (handshake) begin
                issue_q      <= gnt0 ? req0 : req1;
                issue_port_q <= gnt1;
`ifdef DMEM_ARB_RR_EN
                rr_p1_q      <= gnt0;
`endif
            end
            if (state_q == StIssue) begin
                if (issue_port_q) begin
                    rsp_rdata1_q <= rsp_word;
                    rsp_err1_q   <= issue_err;
                end else begin
                    rsp_rdata0_q <= rsp_word;
                    rsp_err0_q   <= issue_err;
                end
            end
        end
    end

    // Outputs are gated by rst so every output reads 0 during the reset cycle itself.
    assign in_issue = (state_q == StIssue) && !rst;
    assign in_resp  = (state_q == StResp) && !rst;

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    assign mem_write  = in_issue && issue_q.write && !issue_err;
    assign mem_addr   = in_issue ? issue_q.addr : 32'h0;
    assign mem_wdata  = in_issue ? issue_q.wdata : 32'h0;
    assign mem_funct3 = in_issue ? issue_q.funct3 : 3'b000;

    assign p0_rsp_valid = in_resp && !issue_port_q;
    assign p1_rsp_valid = in_resp && issue_port_q;
    assign p0_rsp_rdata = rst ? 32'h0 : rsp_rdata0_q;
    assign p1_rsp_rdata = rst ? 32'h0 : rsp_rdata1_q;
    assign p0_rsp_err   = rsp_err0_q && !rst;
    assign p1_rsp_err   = rsp_err1_q && !rst;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter: MEM_WORDS, default 1024, number of 32-bit words in the attached data memory.
REQ-003 Ports SHALL be, in order:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
p0_req_valid/p1_req_valid  in  1  request present (p0 = core load/store, p1 = loader/DMA)
p0_req_ready/p1_req_ready  out  1  request accepted this cycle
pN_req_write  in  1  1 = store, 0 = load
pN_req_addr  in  32  byte address
pN_req_wdata  in  32  store data, low-aligned
pN_req_funct3  in  3  RV32 load/store funct3
pN_rsp_valid  out  1  one-cycle response pulse
pN_rsp_rdata  out  32  load result, 0 for stores/errors
pN_rsp_err  out  1  misaligned or out-of-range access
mem_write  out  1  memory write enable
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_funct3  out  3  memory access size/sign
mem_rdata  in  32  memory combinational read data

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on any handshake, ISSUE->RESP unconditionally, RESP->IDLE unconditionally.
REQ-005 pN_req_ready SHALL be asserted only in IDLE, for at most one port per cycle, and only for the port chosen by arbitration.
REQ-006 Arbitration (fixed priority): p0 SHALL win when both ports are valid in IDLE.
REQ-007 The accepted request (write, addr, wdata, funct3, port id) SHALL be captured into an issue register on the handshake edge; requesters may change inputs afterwards.
REQ-008 In ISSUE the arbiter SHALL drive mem_addr/mem_wdata/mem_funct3 from the issue register, with mem_write = stored write AND NOT error.
REQ-009 mem_write SHALL be 0 in IDLE and RESP; mem_addr/mem_wdata/mem_funct3 SHALL be 0 outside ISSUE.
REQ-010 In ISSUE, mem_rdata SHALL be captured into the response register for loads; stores and errors capture 0.
REQ-011 In RESP the granted port's rsp_valid SHALL be 1 for exactly one cycle; the other port's rsp_valid SHALL stay 0.
REQ-012 Latency: handshake in cycle N -> rsp_valid in cycle N+2; next handshake no earlier than cycle N+3.
REQ-013 Error SHALL be flagged for word access with addr[1:0]!=0, halfword access with addr[0]=1, or addr >= 4*MEM_WORDS; such requests never write memory.
REQ-014 rsp_rdata and rsp_err SHALL hold their values until the next response to the same port.
REQ-015 funct3 SHALL be forwarded unchanged; unsupported encodings are treated as word accesses for alignment checking.

Reset
REQ-016 On rst all outputs SHALL be 0, FSM SHALL enter IDLE, and issue/response registers and the RR pointer SHALL be cleared.
REQ-017 Reset asserted in ISSUE SHALL suppress that cycle's mem_write; an in-flight transaction is dropped with no rsp_valid.
REQ-018 Requests valid during rst SHALL NOT be accepted; acceptance may occur in the first cycle after rst deasserts.

Configuration
REQ-019 With DMEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on contention the port not granted last wins; after reset p0 wins first contention.
REQ-020 Without DMEM_ARB_RR_EN, REQ-006 fixed priority applies and no RR pointer exists.

Structure
REQ-021 Package dmem_arb_pkg SHALL hold the FSM state enum, funct3 load/store encoding constants, and the request struct (write, addr, wdata, funct3).
REQ-022 Sub-module dmem_arb_align_chk (combinational alignment/range check, producing err) is natural; all sequencing stays in dmem_arbiter.

Verification
REQ-023 p0 SW addr 0x10 data 0xDEADBEEF, then p0 LW 0x10 -> mem_write only in ISSUE of the first access; second access gives rsp_rdata 0xDEADBEEF, err 0, rsp_valid at N+2.
REQ-024 p0 and p1 valid simultaneously in IDLE, without RR -> p0 granted twice in a row while p1 waits; with DMEM_ARB_RR_EN -> grants alternate p0, p1, p0.
REQ-025 p1 LW addr 0x12 -> p1_rsp_err 1, rdata 0, mem_write 0; p1 SH addr 0x13 -> err 1, memory unchanged.
REQ-026 p0 LW addr 0x1000 with MEM_WORDS=1024 -> err 1; LW 0xFFC -> err 0.
REQ-027 rst asserted in ISSUE of a p0 SW -> no mem_write, no rsp_valid, all outputs 0; first post-reset request is accepted in the first cycle after rst deasserts.
